// File: rtl/gray_pkg.sv
// Shared types and conversion helpers for the Gray/binary stream converter.
// Latency: combinational functions only.
// Backpressure: not applicable (no state).
package gray_pkg;

  typedef enum logic {GRAY2BIN = 1'b0, BIN2GRAY = 1'b1} conv_mode_t;

  // Helpers work on a fixed maximum width; callers zero-extend narrower values
  // and cast the result back down, which leaves the upper bits at zero.
  localparam int unsigned MAX_W = 32;

  // Binary bit i is the XOR of all Gray bits at or above i.
  function automatic logic [MAX_W-1:0] gray2bin(input logic [MAX_W-1:0] g);
    logic [MAX_W-1:0] b;
    b = '0;
    b[MAX_W-1] = g[MAX_W-1];
    for (int i = MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  function automatic logic [MAX_W-1:0] bin2gray(input logic [MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // More than one bit set <=> clearing the lowest set bit leaves something.
  function automatic logic popcount_gt1(input logic [MAX_W-1:0] x);
    return (x & (x - MAX_W'(1))) != '0;
  endfunction

endpackage

// File: rtl/gray_pipe_stage.sv
// One valid/ready register slice carrying {mode, err, data}.
// Latency: 1 cycle.
// Backpressure: accepts when empty or when its own beat leaves this cycle.
module gray_pipe_stage #(
  parameter int unsigned W = 6
) (
  input  logic         clk_i,
  input  logic         reset_n_i,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic         in_mode_i,
  input  logic         in_err_i,
  input  logic [W-1:0] in_data_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic         out_mode_o,
  output logic         out_err_o,
  output logic [W-1:0] out_data_o
);

  logic         vld_q, vld_d;
  logic         mode_q, mode_d;
  logic         err_q, err_d;
  logic [W-1:0] data_q, data_d;
  logic         load;

  // Free when empty or when the held beat is taken downstream this cycle.
  assign in_ready_o = !vld_q || out_ready_i;
  assign load       = in_valid_i && in_ready_o;

  // Next state: refill on accept, otherwise hold (payload frozen while stalled).
  always_comb begin
    vld_d  = vld_q;
    mode_d = mode_q;
    err_d  = err_q;
    data_d = data_q;
    if (in_ready_o) begin
      vld_d = in_valid_i;
    end
    if (load) begin
      mode_d = in_mode_i;
      err_d  = in_err_i;
      data_d = in_data_i;
    end
  end

  // Slice registers; reset empties the slice and zeroes the payload.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      vld_q  <= 1'b0;
      mode_q <= 1'b0;
      err_q  <= 1'b0;
      data_q <= '0;
    end else begin
      vld_q  <= vld_d;
      mode_q <= mode_d;
      err_q  <= err_d;
      data_q <= data_d;
    end
  end

  assign out_valid_o = vld_q;
  assign out_mode_o  = mode_q;
  assign out_err_o   = err_q;
  assign out_data_o  = data_q;

endmodule

// File: rtl/gray_bin_stream_conv.sv
// Streaming Gray<->binary converter with Gray-adjacency checker and error counter.
// Latency: STAGES cycles input to output, 1 beat/cycle throughput.
// Backpressure: out_ready ripples combinationally back through the slices to in_ready.
module gray_bin_stream_conv
  import gray_pkg::*;
#(
  parameter int unsigned WIDTH  = 6,
  parameter int unsigned STAGES = 2,
  parameter int unsigned CNT_W  = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_mode,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_mode,
  output logic [WIDTH-1:0] out_data,
  output logic             out_adj_err,
  input  logic             clr_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  conv_mode_t       in_mode_e;
  logic             accept;
  logic [WIDTH-1:0] conv_data;
  logic             adj_err;
  logic [WIDTH-1:0] prev_gray_q, prev_gray_d;
  logic             prev_vld_q, prev_vld_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign in_mode_e = conv_mode_t'(in_mode);
  assign accept    = in_valid && in_ready;

  // Convert at the input so the slices only carry the finished result.
  always_comb begin
    if (in_mode_e == BIN2GRAY) begin
      conv_data = WIDTH'(bin2gray(MAX_W'(in_data)));
    end else begin
      conv_data = WIDTH'(gray2bin(MAX_W'(in_data)));
    end
  end

  // A Gray beat is suspect if it moved more than one bit from the last Gray beat.
  always_comb begin
    adj_err = (in_mode_e == GRAY2BIN) && prev_vld_q &&
              popcount_gt1(MAX_W'(in_data ^ prev_gray_q));
  end

  // History and counter next state: only accepted Gray beats update history;
  // clear takes priority over a same-cycle increment, and the count sticks at max.
  always_comb begin
    prev_gray_d = prev_gray_q;
    prev_vld_d  = prev_vld_q;
    cnt_d       = cnt_q;
    if (accept && (in_mode_e == GRAY2BIN)) begin
      prev_gray_d = in_data;
      prev_vld_d  = 1'b1;
    end
    if (clr_cnt) begin
      cnt_d = '0;
    end else if (accept && adj_err && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Checker state registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      prev_gray_q <= '0;
      prev_vld_q  <= 1'b0;
      cnt_q       <= '0;
    end else begin
      prev_gray_q <= prev_gray_d;
      prev_vld_q  <= prev_vld_d;
      cnt_q       <= cnt_d;
    end
  end

  assign err_cnt = cnt_q;

  // Index 0 is the converter input, index STAGES the block output.
  logic [STAGES:0]  vld;
  logic [STAGES:0]  rdy;
  logic [STAGES:0]  mode_p;
  logic [STAGES:0]  err_p;
  logic [WIDTH-1:0] dat_p [STAGES+1];

  assign vld[0]      = in_valid;
  assign mode_p[0]   = in_mode;
  assign err_p[0]    = adj_err;
  assign dat_p[0]    = conv_data;
  assign in_ready    = rdy[0];
  assign rdy[STAGES] = out_ready;

  generate
    for (genvar k = 0; k < STAGES; k++) begin : g_stage
      gray_pipe_stage #(.W(WIDTH)) u_stage (
        .clk_i       (clk),
        .reset_n_i   (reset_n),
        .in_valid_i  (vld[k]),
        .in_ready_o  (rdy[k]),
        .in_mode_i   (mode_p[k]),
        .in_err_i    (err_p[k]),
        .in_data_i   (dat_p[k]),
        .out_valid_o (vld[k+1]),
        .out_ready_i (rdy[k+1]),
        .out_mode_o  (mode_p[k+1]),
        .out_err_o   (err_p[k+1]),
        .out_data_o  (dat_p[k+1])
      );
    end
  endgenerate

  assign out_valid   = vld[STAGES];
  assign out_mode    = mode_p[STAGES];
  assign out_adj_err = err_p[STAGES];
  assign out_data    = dat_p[STAGES];

endmodule

// File: tb/tb_gray_bin_stream_conv.sv
module tb_gray_bin_stream_conv;

  localparam int W = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset_n, in_valid, in_mode, out_ready, clr_cnt;
  logic [W-1:0] in_data;
  logic         in_ready, out_valid, out_mode, out_adj_err;
  logic [W-1:0] out_data;
  logic [7:0]   err_cnt;
  logic         in_ready_b, out_valid_b, out_mode_b, out_adj_err_b;
  logic [W-1:0] out_data_b;
  logic [1:0]   err_cnt_b;

  gray_bin_stream_conv #(.WIDTH(W), .STAGES(2), .CNT_W(8)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_mode(in_mode), .in_data(in_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_mode(out_mode), .out_data(out_data),
    .out_adj_err(out_adj_err), .clr_cnt(clr_cnt), .err_cnt(err_cnt));

  gray_bin_stream_conv #(.WIDTH(W), .STAGES(2), .CNT_W(2)) dut_c2 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready_b),
    .in_mode(in_mode), .in_data(in_data), .out_valid(out_valid_b),
    .out_ready(out_ready), .out_mode(out_mode_b), .out_data(out_data_b),
    .out_adj_err(out_adj_err_b), .clr_cnt(clr_cnt), .err_cnt(err_cnt_b));

  typedef struct packed {
    logic         mode;
    logic         err;
    logic [W-1:0] data;
  } beat_t;

  typedef struct {
    logic         mode;
    logic [W-1:0] din;
    logic [W-1:0] dout;
    logic         err;
  } vec_t;

  beat_t exp_q[$];
  beat_t got_q[$];
  int    tests = 0;
  int    fails = 0;

  // Reference model state
  logic [W-1:0] m_prev;
  bit           m_prev_vld;
  int           m_cnt8, m_cnt2;
  bit           stall_prev;
  logic [W+1:0] held;

  function automatic logic [W-1:0] ref_g2b(input logic [W-1:0] g);
    logic [W-1:0] b;
    for (int i = 0; i < W; i++) b[i] = ^(g >> i);
    return b;
  endfunction

  function automatic logic [W-1:0] ref_b2g(input logic [W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, expv, $time);
    end
  endtask

  // One clock cycle: drive inputs, then score the handshakes of this cycle.
  task automatic cycle(input logic rn, input logic v, input logic m,
                       input logic [W-1:0] d, input logic ordy, input logic clr);
    beat_t e, g;
    @(posedge clk);
    #1;
    reset_n = rn; in_valid = v; in_mode = m; in_data = d;
    out_ready = ordy; clr_cnt = clr;
    #1;
    if (!rn) begin
      exp_q.delete();
      m_prev_vld = 0;
      m_cnt8 = 0;
      m_cnt2 = 0;
      stall_prev = 0;
    end else begin
      chk("err_cnt", err_cnt, m_cnt8);
      chk("err_cnt_c2", err_cnt_b, m_cnt2);
      if (stall_prev)
        chk("stall_hold", {out_valid, out_mode, out_adj_err, out_data}, {1'b1, held});
      if (out_valid && out_ready) begin
        g = '{mode: out_mode, err: out_adj_err, data: out_data};
        got_q.push_back(g);
        if (exp_q.size() == 0) begin
          chk("unexpected_out", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("out_beat", g, e);
          chk("out_beat_c2", {out_valid_b, out_data_b}, {1'b1, e.data});
        end
      end
      if (in_valid && in_ready) begin
        e.mode = in_mode;
        e.err  = (in_mode == 1'b0) && m_prev_vld && ($countones(in_data ^ m_prev) > 1);
        e.data = in_mode ? ref_b2g(in_data) : ref_g2b(in_data);
        exp_q.push_back(e);
        if (in_mode == 1'b0) begin
          m_prev = in_data;
          m_prev_vld = 1;
        end
        if (!clr && e.err) begin
          if (m_cnt8 < 255) m_cnt8++;
          if (m_cnt2 < 3) m_cnt2++;
        end
      end
      if (clr) begin
        m_cnt8 = 0;
        m_cnt2 = 0;
      end
      stall_prev = out_valid && !out_ready;
      held = {out_mode, out_adj_err, out_data};
    end
  endtask

  task automatic idle(input logic ordy);
    cycle(1'b1, 1'b0, 1'b0, '0, ordy, 1'b0);
  endtask

  task automatic do_reset();
    cycle(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) idle(1'b1);
    chk("drain_empty", exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t         tbl[5];
    int           sat[5];
    logic [W-1:0] bp_d[10];
    logic         bp_m[10];
    logic [W-1:0] last;
    int           idx, cyc;
    logic         v, m, ordy, clr, rn;
    logic [W-1:0] d;

    reset_n = 0; in_valid = 0; in_mode = 0; in_data = '0; out_ready = 0; clr_cnt = 0;
    tbl[0] = '{1'b0, 6'b000001, 6'b000001, 1'b0};
    tbl[1] = '{1'b0, 6'b000011, 6'b000010, 1'b0};
    tbl[2] = '{1'b0, 6'b000011, 6'b000010, 1'b0};
    tbl[3] = '{1'b1, 6'b111111, 6'b100000, 1'b0};
    tbl[4] = '{1'b0, 6'b000110, 6'b000100, 1'b1};
    sat = '{1, 2, 3, 3, 3};

    // Reset state
    do_reset();
    idle(1'b1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_mode", out_mode, 0);
    chk("rst_out_adj_err", out_adj_err, 0);
    chk("rst_err_cnt", err_cnt, 0);

    // Latency and basic conversion in both directions
    cycle(1'b1, 1'b1, 1'b0, 6'b100110, 1'b1, 1'b0);
    idle(1'b1);
    chk("lat_g2b_c1", out_valid, 0);
    idle(1'b1);
    chk("lat_g2b_c2", {out_valid, out_mode, out_data}, {1'b1, 1'b0, 6'b111011});
    cycle(1'b1, 1'b1, 1'b1, 6'b111011, 1'b1, 1'b0);
    idle(1'b1);
    chk("lat_b2g_c1", out_valid, 0);
    idle(1'b1);
    chk("lat_b2g_c2", {out_valid, out_mode, out_data}, {1'b1, 1'b1, 6'b100110});

    // Adjacency table
    do_reset();
    got_q.delete();
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b1, tbl[i].mode, tbl[i].din, 1'b1, 1'b0);
    drain();
    chk("tbl_count", got_q.size(), 5);
    for (int i = 0; i < 5 && i < got_q.size(); i++)
      chk($sformatf("tbl_%0d", i), got_q[i], {tbl[i].mode, tbl[i].err, tbl[i].dout});
    chk("tbl_err_cnt", err_cnt, 1);

    // Exhaustive round trip, one beat per cycle
    do_reset();
    got_q.delete();
    for (int x = 0; x < 64; x++) begin
      cycle(1'b1, 1'b1, 1'b1, W'(x), 1'b1, 1'b0);
      chk("exh_in_ready", {in_ready, in_ready_b}, 2'b11);
    end
    for (int x = 0; x < 64; x++) begin
      cycle(1'b1, 1'b1, 1'b0, ref_b2g(W'(x)), 1'b1, 1'b0);
      chk("exh_in_ready", {in_ready, in_ready_b}, 2'b11);
    end
    drain();
    chk("exh_count", got_q.size(), 128);
    for (int x = 0; x < 64 && 64 + x < got_q.size(); x++)
      chk("roundtrip", got_q[64+x].data, x);
    chk("exh_err_cnt", err_cnt, 0);

    // Full pipeline with out_ready low blocks the input
    do_reset();
    got_q.delete();
    cycle(1'b1, 1'b1, 1'b0, 6'h05, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b0, 6'h04, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b0, 6'h0C, 1'b0, 1'b0);
    chk("full_in_ready", {in_ready, in_ready_b}, 2'b00);
    drain();
    chk("full_count", got_q.size(), 2);

    // Backpressure stream, out_ready 1,0,0,1,0,0,...
    got_q.delete();
    for (int i = 0; i < 10; i++) begin
      bp_d[i] = W'($urandom);
      bp_m[i] = 1'($urandom_range(0, 1));
    end
    idx = 0;
    cyc = 0;
    while (idx < 10 && cyc < 200) begin
      cycle(1'b1, 1'b1, bp_m[idx], bp_d[idx], (cyc % 3) == 0, 1'b0);
      if (in_ready) idx++;
      cyc++;
    end
    chk("bp_all_sent", idx, 10);
    drain();
    chk("bp_count", got_q.size(), 10);

    // Saturation with a 2-bit counter, then clear beating an increment
    do_reset();
    cycle(1'b1, 1'b1, 1'b0, 6'h00, 1'b1, 1'b0);
    for (int k = 0; k < 5; k++) begin
      cycle(1'b1, 1'b1, 1'b0, (k % 2 == 0) ? 6'h3F : 6'h00, 1'b1, 1'b0);
      idle(1'b1);
      chk($sformatf("sat_%0d", k), err_cnt_b, sat[k]);
    end
    cycle(1'b1, 1'b1, 1'b0, 6'h00, 1'b1, 1'b1);
    idle(1'b1);
    chk("clr_wins_c2", err_cnt_b, 0);
    chk("clr_wins", err_cnt, 0);
    drain();

    // Reset with two beats in flight
    do_reset();
    cycle(1'b1, 1'b1, 1'b0, 6'h00, 1'b1, 1'b0);
    cycle(1'b1, 1'b1, 1'b0, 6'h3F, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b0, 6'h2A, 1'b1, 1'b0);
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_err_cnt", {err_cnt_b, err_cnt}, 0);
    idle(1'b1);
    chk("mid_rst_flush", out_valid, 0);
    idle(1'b1);
    chk("mid_rst_first", {out_valid, out_adj_err, out_data}, {1'b1, 1'b0, ref_g2b(6'h2A)});

    // Randomised traffic against the model
    do_reset();
    last = '0;
    for (int n = 0; n < 600; n++) begin
      rn   = ($urandom_range(0, 199) != 0);
      v    = rn && ($urandom_range(0, 3) != 0);
      m    = ($urandom_range(0, 3) == 0);
      d    = $urandom_range(0, 1) ? (last ^ W'(1 << $urandom_range(0, W - 1))) : W'($urandom);
      ordy = rn && ($urandom_range(0, 3) != 0);
      clr  = ($urandom_range(0, 40) == 0);
      cycle(rn, v, m, d, ordy, clr);
      if (v) last = d;
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
